conv1_window_gen: RTL and testbench

Streaming 5x5 sliding-window generator that feeds the 25-tap conv1 PE. Accepts one unsigned 8-bit pixel per cycle of the input image in raster order. Holds K-1 line buffers plus a KxK window register array. Emits one complete window, flattened as 25 taps, for every valid output position (valid convolution, stride 1, no padding).

---
 rtl/conv1_window_gen.sv | 170 +++++++++++++++++
 tb/tb_conv1_window_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/conv1_window_gen.sv
// Streaming KxK sliding-window generator for the conv1 PE (valid convolution, stride 1).
// Optional macro WIN_COORD_EN adds out_x/out_y output-position coordinates.
module conv1_window_gen #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K     = 5,
  parameter int DW    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_pixel,
  output logic                  out_valid,
  output logic [K*K*DW-1:0]     win,
  output logic                  busy,
`ifdef WIN_COORD_EN
  output logic [$clog2(IMG_W)-1:0] out_x,
  output logic [$clog2(IMG_W)-1:0] out_y,
`endif
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_GATE = CW'(K - 1);
  localparam logic [RW-1:0] ROW_GATE = RW'(K - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CW-1:0]     col_r;
  logic [RW-1:0]     row_r;
  logic              accept_s;
  logic              last_px_s;
  logic              emit_s;
  logic [K*K*DW-1:0] win_flat_s;

  // lb_r[i] holds image row (row_r - (K-1) + i); lb_r[K-2] is the row just above.
  logic [DW-1:0] lb_r       [K-1][IMG_W];
  logic [DW-1:0] win_arr_r  [K][K];
  logic [DW-1:0] win_nxt_s  [K][K];

  assign accept_s  = in_valid & in_ready;
  assign last_px_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
  // Gating on col suppresses windows that would straddle a row wrap.
  assign emit_s    = (row_r >= ROW_GATE) && (col_r >= COL_GATE);

  // Next window: shift every row left, new column enters on the right.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_nxt_s[r][c] = win_arr_r[r][c+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_nxt_s[r][K-1] = lb_r[r][col_r];
    end
    win_nxt_s[K-1][K-1] = in_pixel;
  end

  // Flatten next window as tap k = r*K + c.
  always_comb begin
    win_flat_s = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat_s[(r*K+c)*DW +: DW] = win_nxt_s[r][c];
      end
    end
  end

  // Frame FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && last_px_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and status outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready   <= (state_nxt_s == ST_RUN);
      busy       <= (state_nxt_s != ST_IDLE);
      frame_done <= (state_nxt_s == ST_DONE);
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= '0;
      row_r <= '0;
    end else if ((state_r == ST_IDLE) && start) begin
      col_r <= '0;
      row_r <= '0;
    end else if (accept_s) begin
      if (col_r == COL_LAST) begin
        col_r <= '0;
        row_r <= row_r + ROW_ONE;
      end else begin
        col_r <= col_r + COL_ONE;
      end
    end
  end

  // Registered window output; holds until the next emitted window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      win       <= '0;
`ifdef WIN_COORD_EN
      out_x     <= '0;
      out_y     <= '0;
`endif
    end else begin
      out_valid <= accept_s & emit_s;
      if (accept_s && emit_s) begin
        win   <= win_flat_s;
`ifdef WIN_COORD_EN
        out_x <= col_r - COL_GATE;
        out_y <= CW'(row_r - ROW_GATE);
`endif
      end
    end
  end

  // Line buffers and window array; contents are refilled before any emission.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int i = 0; i < K - 2; i++) begin
        lb_r[i][col_r] <= lb_r[i+1][col_r];
      end
      lb_r[K-2][col_r] <= in_pixel;
      win_arr_r        <= win_nxt_s;
    end
  end

endmodule

// File: tb/tb_conv1_window_gen.sv
// Scoreboard bench for conv1_window_gen: driver pushes expected windows, monitor pops on out_valid.
module tb_conv1_window_gen;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int K  = 5;
  localparam int NW = (W-K+1)*(H-K+1);
  localparam int WB = K*K*8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_pixel = 8'd0;
  logic          out_valid;
  logic [WB-1:0] win;
  logic          busy;
  logic          frame_done;
`ifdef WIN_COORD_EN
  logic [4:0]    out_x;
  logic [4:0]    out_y;
`endif

  conv1_window_gen #(.IMG_W(W), .IMG_H(H), .K(K), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .out_valid(out_valid), .win(win), .busy(busy),
`ifdef WIN_COORD_EN
    .out_x(out_x), .out_y(out_y),
`endif
    .frame_done(frame_done));

  always #5 clk = ~clk;

  typedef struct {
    logic [WB-1:0] w;
    int due;
    int x;
    int y;
    int idx;
    bit last;
    bit ramp;
  } exp_t;

  exp_t       q[$];
  logic [7:0] img [H][W];
  int vectors = 0, miscompares = 0, cyc = 0, n_pop = 0, n_fd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input bit ramp);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = ramp ? 8'((r*32 + c) & 255) : 8'($urandom_range(0, 255));
  endtask

  task automatic push(input int r, input int c, input bit ramp);
    exp_t e;
    if (r >= K-1 && c >= K-1) begin
      e.w = '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          e.w[(i*K+j)*8 +: 8] = img[r-K+1+i][c-K+1+j];
      e.due  = cyc + 1;
      e.x    = c - (K-1);
      e.y    = r - (K-1);
      e.idx  = e.y*(W-K+1) + e.x;
      e.last = (r == H-1) && (c == W-1);
      e.ramp = ramp;
      q.push_back(e);
    end
  endtask

  // Monitor: compare every presented window against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          n_pop++;
          chk("win", win, e.w);
          chk("latency", cyc, e.due);
          chk("frame_done_with_last", frame_done, e.last);
`ifdef WIN_COORD_EN
          chk("out_x", out_x, e.x);
          chk("out_y", out_y, e.y);
`endif
          if (e.ramp && e.idx == 0) begin
            chk("first_tap0", win[0*8 +: 8], 8'd0);
            chk("first_tap12", win[12*8 +: 8], 8'd66);
            chk("first_tap24", win[24*8 +: 8], 8'd132);
          end
          if (e.ramp && e.idx == 27) begin
            chk("wrap_tap4", win[4*8 +: 8], 8'd31);
            chk("wrap_tap24", win[24*8 +: 8], 8'd159);
          end
          if (e.ramp && e.idx == 28) chk("after_wrap_tap0", win[0*8 +: 8], 8'd32);
          if (e.ramp && e.idx == NW-1) begin
            chk("last_tap0", win[0*8 +: 8], 8'd123);
            chk("last_tap24", win[24*8 +: 8], 8'd255);
          end
        end
      end else if (frame_done) begin
        chk("frame_done_without_window", frame_done, 1'b0);
      end
      if (frame_done) n_fd++;
    end
  end

  task automatic run_frame(input bit ramp, input int gap_pct, input int abort_at);
    int base_pop, base_fd, r, c;
    fill(ramp);
    base_pop = n_pop;
    base_fd  = n_fd;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("in_ready_run", in_ready, 1'b1);
    chk("busy_run", busy, 1'b1);
    for (int i = 0; i < W*H; i++) begin
      r = i / W;
      c = i % W;
      if (i == abort_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_win", win, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_frame_done_count", n_fd - base_fd, 0);
        return;
      end
      for (int g = 0; g < 6 && $urandom_range(0, 99) < gap_pct; g++) begin
        in_valid = 1'b0;
        in_pixel = 8'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_pixel = img[r][c];
      start    = (i == 300) || (i == W*H-1);
      push(r, c, ramp);
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("window_count", n_pop - base_pop, NW);
    chk("frame_done_count", n_fd - base_fd, 1);
    chk("idle_in_ready", in_ready, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_win", win, '0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_pixel = 8'($urandom);
      tick();
      chk("idle_ignores_in_valid", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    run_frame(1'b1, 0, -1);
    run_frame(1'b1, 40, -1);
    run_frame(1'b1, 0, 500);
    run_frame(1'b0, 0, -1);
    run_frame(1'b0, 25, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
